dmac_rd: RTL
============

DMAC_RD -- requirements
Module: dmac_rd

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning line-buffer word / AXI-stream data width in bits (32 bytes per beat).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AXI byte-address width.
REQ-003 SHALL have parameter MEM_AW, default 9, meaning line-buffer word-address width.
REQ-004 SHALL have parameter LEN_W, default 20, meaning descriptor byte-length width.
REQ-005 Ports SHALL be as follows:
- aclk  in  1  clock; all logic posedge aclk.
- rst_n  in  1  reset, asynchronous, active-low.
- dma_trigger_i  in  1  one-cycle request to fetch one image line.
- image_width_i  in  12  line width in 8-bit pixels (= bytes).
- line_addr_i  in  ADDR_W  base byte address of the frame.
- addr_update_i  in  1  one-cycle request to load line_addr_i.
- addr_update_done_o  out  1  one-cycle acknowledge of the address load.
- desc_valid_o  out  1  read-descriptor valid.
- desc_ready_i  in  1  read-descriptor ready.
- desc_addr_o  out  ADDR_W  descriptor byte address.
- desc_len_o  out  LEN_W  descriptor byte length.
- rd_data_i  in  DATA_W  AXI-stream read data.
- rd_valid_i  in  1  stream valid.
- rd_last_i  in  1  stream last.
- rd_ready_o  out  1  stream ready.
- mem_wr_o  out  1  line-buffer write strobe.
- mem_addr_o  out  MEM_AW  line-buffer word address.
- mem_data_o  out  DATA_W  line-buffer write data.
- dma_trigger_done_o  out  1  one-cycle line-complete pulse.
- err_o  out  1  sticky length/overrun error flag.

Function
REQ-006 SHALL implement FSM IDLE -> DESC -> DATA -> DONE -> IDLE.
REQ-007 In IDLE, dma_trigger_i with image_width_i != 0 SHALL latch the width, compute words = ceil(width/32), and move to DESC; with width == 0 it SHALL pulse dma_trigger_done_o the next cycle and stay in IDLE.
REQ-008 In DESC, desc_valid_o SHALL be 1 with desc_addr_o = cur_addr and desc_len_o = zero-extended width; these SHALL stay stable until desc_valid_o && desc_ready_i, then the FSM SHALL move to DATA.
REQ-009 In DATA, rd_ready_o SHALL be 1. Each beat with rd_valid_i && rd_ready_o SHALL produce, on the next cycle, mem_wr_o = 1, mem_data_o = rd_data_i and mem_addr_o = word count, where the word count starts at 0.
REQ-010 The beat with word count == words-1 SHALL end DATA and move to DONE; rd_ready_o SHALL be 0 outside DATA.
REQ-011 DONE SHALL last one cycle with dma_trigger_done_o = 1, and SHALL advance cur_addr += width rounded up to a multiple of 32, with ADDR_W wrap-around (no saturation).
REQ-012 dma_trigger_i outside IDLE SHALL be ignored and SHALL set err_o.
REQ-013 addr_update_i in IDLE SHALL load cur_addr = line_addr_i and pulse addr_update_done_o on the next cycle.
REQ-014 addr_update_i outside IDLE SHALL be held pending and applied on the first IDLE cycle, pulsing addr_update_done_o one cycle later. If addr_update_i coincides with the DONE advance, the load SHALL win.
REQ-015 If addr_update_i and dma_trigger_i occur in the same IDLE cycle, the address load SHALL take effect first, so the triggered descriptor uses the new base.
REQ-016 err_o SHALL be cleared when a trigger is accepted in IDLE.

Reset
REQ-017 While rst_n = 0, the FSM SHALL be in IDLE, cur_addr and all counters SHALL be 0, the pending flag SHALL be cleared, and every output SHALL be 0. A reset mid-line SHALL abandon the line with no done pulse.

Configuration
REQ-018 With DMAC_RD_TLAST_CHECK_EN defined, the following SHALL set err_o:
- rd_last_i = 1 on a beat other than words-1, which SHALL also terminate the line early into DONE;
- rd_last_i = 0 on beat words-1.
REQ-019 Without DMAC_RD_TLAST_CHECK_EN, rd_last_i SHALL be ignored and only REQ-012 SHALL set err_o.

Structure
REQ-020 Package dma_pkg SHALL hold:
- the FSM state enum;
- BYTES_PER_WORD = DATA_W/8;
- a words_from_width() ceil function.
REQ-021 cur_addr, the pending update and the advance SHALL live in the sub-module dmac_rd_addr_gen; the FSM and write path SHALL stay in dmac_rd.

Verification
REQ-022 Load base 0x1000_0000, width 640, desc_ready_i held 1, 20 beats -> desc_len_o = 640, mem_addr_o 0..19, one done pulse, next desc_addr_o = 0x1000_0280.
REQ-023 Width 33 -> desc_len_o = 33, 2 beats written, next address advances by 64.
REQ-024 Width 0 trigger -> no descriptor, done pulse 1 cycle later, err_o = 0.
REQ-025 desc_ready_i low 5 cycles, then rd_valid_i toggled 1/0 -> desc fields stable throughout, one write per accepted beat only.
REQ-026 Trigger and addr_update_i mid-DATA -> err_o = 1, update applied after DONE, addr_update_done_o pulses once.
REQ-027 With the macro defined, rd_last_i on beat 3 of 20 -> done after beat 3, err_o = 1; rst_n pulsed mid-line -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg -- shared definitions for the line-fetch DMA read engine (dmac_rd).
//   dmac_state_e      : read FSM states (IDLE -> DESC -> DATA -> DONE)
//   DMA_DATA_W        : default line-buffer / stream word width in bits
//   BYTES_PER_WORD    : bytes carried by one default-width stream beat
//   words_from_width(): ceil(width / bytes_per_word), the beat count of a line
package dma_pkg;

  localparam int unsigned DMA_DATA_W     = 256;
  localparam int unsigned BYTES_PER_WORD = DMA_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DESC = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dmac_state_e;

  // Number of stream beats needed to carry 'width' bytes. 12-bit widths need
  // at most 4095 beats (bpw = 1), so 13 bits are always enough.
  function automatic logic [12:0] words_from_width(input logic [11:0]  width,
                                                    input int unsigned bpw);
    logic [31:0] w;
    w = (32'(width) + bpw - 32'd1) / bpw;
    return w[12:0];
  endfunction

endpackage

// File: rtl/dmac_rd_if.sv
// dmac_rd_if -- read-descriptor and AXI-stream read-data bundle of dmac_rd.
// Signal names are taken from the DMA engine's point of view.
//   desc_valid_o / desc_ready_i : descriptor handshake, desc_addr_o/desc_len_o payload
//   rd_valid_i   / rd_ready_o   : stream handshake, rd_data_i/rd_last_i payload
// Handshake rule for both channels: a transfer happens on a rising aclk edge
// where valid and ready are both 1; the source holds valid and its payload
// stable until that edge and never withdraws valid; ready may toggle freely.
// Modports: master = DMA engine, slave = descriptor/stream provider.
interface dmac_rd_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20
);
  logic              desc_valid_o;
  logic              desc_ready_i;
  logic [ADDR_W-1:0] desc_addr_o;
  logic [LEN_W-1:0]  desc_len_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_valid_i;
  logic              rd_last_i;
  logic              rd_ready_o;

  modport master (
    output desc_valid_o, desc_addr_o, desc_len_o, rd_ready_o,
    input  desc_ready_i, rd_data_i, rd_valid_i, rd_last_i
  );

  modport slave (
    input  desc_valid_o, desc_addr_o, desc_len_o, rd_ready_o,
    output desc_ready_i, rd_data_i, rd_valid_i, rd_last_i
  );
endinterface

// File: rtl/dmac_rd_addr_gen.sv
// dmac_rd_addr_gen -- current line address tracker for dmac_rd.
// Ports:
//   aclk, rst_n          : clock, asynchronous active-low reset
//   idle_i               : read FSM is in IDLE (address loads allowed)
//   advance_i            : end-of-line strobe, cur_addr += adv_bytes_i
//   adv_bytes_i          : line length rounded up to whole beats, in bytes
//   addr_update_i        : request to load line_addr_i
//   line_addr_i          : new base address
//   cur_addr_o           : address used for the next descriptor
//   addr_update_done_o   : one-cycle acknowledge, cycle after the load
// A request seen outside IDLE is parked (with its address) and applied on the
// first IDLE cycle; since advance only occurs in DONE, a parked load always
// lands after the advance and therefore wins over it.
module dmac_rd_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              idle_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] adv_bytes_i,
  input  logic              addr_update_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic              addr_update_done_o
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              upd_done_q, upd_done_d;

  always_comb begin
    cur_addr_d  = cur_addr_q;
    pend_addr_d = pend_addr_q;
    pend_d      = pend_q;
    upd_done_d  = 1'b0;
    // Wrap-around add: the address space is circular by design.
    if (advance_i) begin
      cur_addr_d = cur_addr_q + adv_bytes_i;
    end
    if (idle_i) begin
      // A fresh request in IDLE supersedes an older parked one.
      if (addr_update_i) begin
        cur_addr_d = line_addr_i;
        pend_d     = 1'b0;
        upd_done_d = 1'b1;
      end else if (pend_q) begin
        cur_addr_d = pend_addr_q;
        pend_d     = 1'b0;
        upd_done_d = 1'b1;
      end
    end else if (addr_update_i) begin
      pend_d      = 1'b1;
      pend_addr_d = line_addr_i;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      upd_done_q  <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      upd_done_q  <= upd_done_d;
    end
  end

  assign cur_addr_o         = cur_addr_q;
  assign addr_update_done_o = upd_done_q;

endmodule

// File: rtl/dmac_rd.sv
// dmac_rd -- fetches one image line per trigger: issues a read descriptor for
// the current line address, writes the returned stream beats into a line
// buffer at word addresses 0..words-1, pulses done and advances the address.
// Ports:
//   aclk, rst_n                    : clock, asynchronous active-low reset
//   dma_trigger_i, image_width_i   : line request and its width in bytes
//   line_addr_i, addr_update_i     : base-address load request
//   addr_update_done_o             : base-address load acknowledge
//   bus (dmac_rd_if.master)        : descriptor channel + stream read channel
//   mem_wr_o/mem_addr_o/mem_data_o : line-buffer write port
//   dma_trigger_done_o             : one-cycle line-complete pulse
//   err_o                          : sticky error, cleared by an accepted trigger
// Build option DMAC_RD_TLAST_CHECK_EN: checks rd_last_i against the expected
// last beat; an early last ends the line, any disagreement sets err_o.
// Without it rd_last_i is ignored.
module dmac_rd
  import dma_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 9,
  parameter int LEN_W  = 20
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              dma_trigger_i,
  input  logic [11:0]       image_width_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  input  logic              addr_update_i,
  output logic              addr_update_done_o,
  dmac_rd_if.master         bus,
  output logic              mem_wr_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              dma_trigger_done_o,
  output logic              err_o
);

  localparam int unsigned BPW = DATA_W / 8;

  dmac_state_e       state_q;
  logic [11:0]       width_q;
  logic [12:0]       words_q;
  logic [MEM_AW-1:0] cnt_q;
  logic              desc_valid_q;
  logic              rd_ready_q;
  logic              mem_wr_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              done_q;
  logic              err_q;

  logic              last_beat;
  logic              beat;
  logic [ADDR_W-1:0] adv_bytes;
  logic [ADDR_W-1:0] cur_addr;

  assign beat      = bus.rd_valid_i && rd_ready_q;
  assign last_beat = (13'(cnt_q) == (words_q - 13'd1));
  // Line footprint rounded up to whole beats.
  assign adv_bytes = ADDR_W'(words_q) * ADDR_W'(BPW);

`ifndef DMAC_RD_TLAST_CHECK_EN
  logic unused_rd_last;
  assign unused_rd_last = bus.rd_last_i;
`endif

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      words_q      <= '0;
      cnt_q        <= '0;
      desc_valid_q <= 1'b0;
      rd_ready_q   <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      if (dma_trigger_i && (state_q != ST_IDLE)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (dma_trigger_i) begin
            err_q <= 1'b0;
            if (image_width_i != 12'd0) begin
              width_q      <= image_width_i;
              words_q      <= words_from_width(image_width_i, BPW);
              desc_valid_q <= 1'b1;
              state_q      <= ST_DESC;
            end else begin
              // Empty line: nothing to fetch, just acknowledge.
              done_q <= 1'b1;
            end
          end
        end
        ST_DESC: begin
          if (bus.desc_ready_i) begin
            desc_valid_q <= 1'b0;
            rd_ready_q   <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= cnt_q;
            mem_data_q <= bus.rd_data_i;
            cnt_q      <= cnt_q + 1'b1;
`ifdef DMAC_RD_TLAST_CHECK_EN
            if (last_beat != bus.rd_last_i) begin
              err_q <= 1'b1;
            end
            if (last_beat || bus.rd_last_i) begin
              rd_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end
`else
            if (last_beat) begin
              rd_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dmac_rd_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .aclk               (aclk),
    .rst_n              (rst_n),
    .idle_i             (state_q == ST_IDLE),
    .advance_i          (state_q == ST_DONE),
    .adv_bytes_i        (adv_bytes),
    .addr_update_i      (addr_update_i),
    .line_addr_i        (line_addr_i),
    .cur_addr_o         (cur_addr),
    .addr_update_done_o (addr_update_done_o)
  );

  assign bus.desc_valid_o   = desc_valid_q;
  assign bus.desc_addr_o    = cur_addr;
  assign bus.desc_len_o     = LEN_W'(width_q);
  assign bus.rd_ready_o     = rd_ready_q;
  assign mem_wr_o           = mem_wr_q;
  assign mem_addr_o         = mem_addr_q;
  assign mem_data_o         = mem_data_q;
  assign dma_trigger_done_o = done_q;
  assign err_o              = err_q;

endmodule
